usb_rx_crc16_checker: RTL and testbench
=======================================

# usb_rx_crc16_checker

Sequencing controller for the serial CRC-16 datapath on the USB receive side. It frames each DATA packet from `pkt_start` to `eop` and clears and steps the CRC-16 register one bit per qualified receive bit. At end of packet it checks the CRC residual and the bit count, then reports a single pass/fail result. It sits between the NRZI-decode/bit-unstuff stage and the RX packet FSM that owns the endpoint FIFO.

## Interface
Reset and clock: reset n_rst, asynchronous, active-low; clock clk.

Parameters:
- MAX_PAYLOAD_BYTES, 64, largest legal payload. The CRC field is excluded.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- pkt_start  in  1  one-cycle pulse; first data-field bit follows
- bit_valid  in  1  qualifies bit_in (unstuffed, decoded, LSB-first)
- bit_in  in  1  received data/CRC bit
- eop  in  1  one-cycle pulse; end of packet
- abort  in  1  bit-stuff or PHY error; discard packet, no report
- busy  out  1  high in ACCUM
- result_valid  out  1  one-cycle pulse; result fields valid
- crc_ok  out  1  residual matched and length legal
- len_err  out  1  bit count not a multiple of 8, under 16 bits, or over (MAX_PAYLOAD_BYTES+2)*8
- byte_count  out  7  payload bytes = total bytes − 2 (0 when len_err)

## Operation
- States: IDLE, ACCUM, REPORT.
- IDLE:
  - pkt_start → ACCUM.
  - Engine is loaded with 16'hFFFF and the bit counter is cleared in the cycle of pkt_start.
- ACCUM:
  - Each bit_valid shifts bit_in into the engine and increments the 10-bit bit counter.
  - eop → REPORT.
  - pkt_start → restart: engine preset, counter cleared, stay in ACCUM, no report.
- REPORT:
  - Lasts one cycle, then → IDLE.
  - pkt_start in REPORT is honoured and goes → ACCUM.
- abort has the highest priority in every state: → IDLE, result fields unchanged, no result_valid.
- CRC register and residual:
  - Feedback polynomial x^16+x^15+x^2+1.
  - next[0]=crc[15]^bit, next[1]=crc[0], next[2]=crc[15]^crc[1], next[14:3]=crc[13:2], next[15]=crc[15]^crc[14].
  - After the data and received CRC bits, a good packet leaves the register at 16'h800D.
- Bit counter:
  - Saturates at 1023.
  - Overflow beyond (MAX_PAYLOAD_BYTES+2)*8 forces len_err.
  - Bits after overflow are still accepted and ignored until eop.
- Result computation:
  - crc_ok = (crc==16'h800D) && !len_err.
  - byte_count = bit_count/8 − 2, truncated to 7 bits.
- Engine is not stepped when bit_valid=0; idle cycles are permitted anywhere in a packet.

## Timing
- Reset values:
  - state IDLE, crc 16'hFFFF, bit counter 0.
  - busy=0, result_valid=0, crc_ok=0, len_err=0, byte_count=0.
- bit_valid and eop in the same cycle N:
  - The bit is included.
  - Results are computed from the post-shift crc and count at the edge ending cycle N.
- eop in cycle N:
  - result_valid=1 in cycle N+1 only.
  - crc_ok, len_err and byte_count are registered and stable from N+1 until the next pkt_start or reset.
- pkt_start clears crc_ok, len_err and byte_count in the following cycle.
- eop while in IDLE or REPORT: ignored.
- bit_valid while in IDLE: ignored.
- Reset mid-packet returns everything to the reset values immediately, asynchronously.
- Latency from final bit to result: 1 cycle. Throughput: one bit per clk.

## Structure
- Package usb_rx_crc_pkg:
  - state enum {IDLE, ACCUM, REPORT}.
  - CRC16_PRESET=16'hFFFF, CRC16_RESIDUAL=16'h800D.
  - Bit counter width BITCNT_W=10.
- One sub-module, crc16_serial_engine:
  - Ports: clk, n_rst, clear, shift_en, bit_in, crc[15:0].
  - clear has priority over shift_en.
  - The controller drives clear and shift_en and owns the FSM, counter and result registers.

## Test plan
- Zero-length packet: pkt_start, bits 0x00,0x00 (16 zeros), eop → result_valid at eop+1, crc_ok=1, len_err=0, byte_count=0.
- Same packet with the second CRC byte 0x01 → crc_ok=0, len_err=0, byte_count=0.
- 12 bits then eop → len_err=1, crc_ok=0, byte_count=0.
- 67 bytes with MAX_PAYLOAD_BYTES=64 → len_err=1, crc_ok=0; the counter does not wrap.
- abort midway through ACCUM, then a good zero-length packet → no result_valid for the aborted packet; the second packet gives crc_ok=1.
- Edge cases on the good zero-length packet:
  - Last bit coincident with eop → crc_ok=1.
  - Random bit_valid gaps → crc_ok=1.
  - pkt_start issued in REPORT → next packet is accepted with no lost cycle.
  - n_rst asserted in ACCUM → all outputs 0 and the engine returns to 16'hFFFF.

Source files
------------

// File: rtl/usb_rx_crc_pkg.sv
// Shared types, constants and the serial CRC-16 step function for the USB RX CRC checker.
package usb_rx_crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_e;

    localparam logic [15:0] CRC16_PRESET   = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam int          BITCNT_W       = 10;

    // One serial step of the x^16+x^15+x^2+1 register; shared so the controller can
    // see the post-shift value in the same cycle the engine takes it.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic [15:0] nxt;
        nxt[0]    = crc[15] ^ bit_in;
        nxt[1]    = crc[0];
        nxt[2]    = crc[15] ^ crc[1];
        nxt[14:3] = crc[13:2];
        nxt[15]   = crc[15] ^ crc[14];
        return nxt;
    endfunction

endpackage

// File: rtl/crc16_serial_engine.sv
// Serial CRC-16 register: preset on clear, one bit per cycle on shift_en.
module crc16_serial_engine
    import usb_rx_crc_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC16_PRESET;
        end else if (shift_en) begin
            crc_d = crc16_step(crc_q, bit_in);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= CRC16_PRESET;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_rx_crc16_checker.sv
// Frames a USB DATA packet from pkt_start to eop, steps the CRC engine per received bit
// and reports one registered pass/fail result with the payload byte count.
module usb_rx_crc16_checker
    import usb_rx_crc_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       pkt_start,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       eop,
    input  logic       abort,
    output logic       busy,
    output logic       result_valid,
    output logic       crc_ok,
    output logic       len_err,
    output logic [6:0] byte_count
);

    localparam int unsigned MAX_BITS = (MAX_PAYLOAD_BYTES + 2) * 8;

    state_e              state_q, state_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                crc_ok_q, crc_ok_d;
    logic                len_err_q, len_err_d;
    logic [6:0]          byte_count_q, byte_count_d;

    logic [15:0]         crc;
    logic [15:0]         crc_post;
    logic [BITCNT_W-1:0] cnt_post;
    logic [6:0]          bytes_post;
    logic                len_bad;
    logic                engine_clear, engine_shift;

    crc16_serial_engine u_engine (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (engine_clear),
        .shift_en (engine_shift),
        .bit_in   (bit_in),
        .crc      (crc)
    );

    // Values as they stand after this cycle's bit, so a bit coincident with eop is counted.
    always_comb begin
        cnt_post = bit_cnt_q;
        crc_post = crc;
        if (bit_valid) begin
            cnt_post = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 1'b1;
            crc_post = crc16_step(crc, bit_in);
        end
        len_bad    = (cnt_post[2:0] != 3'd0) || (cnt_post < BITCNT_W'(16)) ||
                     (32'(cnt_post) > MAX_BITS);
        bytes_post = cnt_post[BITCNT_W-1:3] - 7'd2;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        crc_ok_d     = crc_ok_q;
        len_err_d    = len_err_q;
        byte_count_d = byte_count_q;
        engine_clear = 1'b0;
        engine_shift = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else if (pkt_start) begin
            // A start in any state (including a restart mid-packet) opens a fresh frame.
            state_d      = ACCUM;
            bit_cnt_d    = '0;
            engine_clear = 1'b1;
            crc_ok_d     = 1'b0;
            len_err_d    = 1'b0;
            byte_count_d = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    engine_shift = bit_valid;
                    bit_cnt_d    = cnt_post;
                    if (eop) begin
                        state_d      = REPORT;
                        len_err_d    = len_bad;
                        crc_ok_d     = (crc_post == CRC16_RESIDUAL) && !len_bad;
                        byte_count_d = len_bad ? 7'd0 : bytes_post;
                    end
                end
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            crc_ok_q     <= crc_ok_d;
            len_err_q    <= len_err_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign busy         = (state_q == ACCUM);
    assign result_valid = (state_q == REPORT);
    assign crc_ok       = crc_ok_q;
    assign len_err      = len_err_q;
    assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_usb_rx_crc16_checker.sv
// Self-checking bench for usb_rx_crc16_checker: table of packets plus hand sequences,
// expected results queued on eop and compared when result_valid appears.
module tb_usb_rx_crc16_checker;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       pkt_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       eop = 1'b0;
    logic       abort = 1'b0;
    logic       busy, result_valid, crc_ok, len_err;
    logic [6:0] byte_count;

    usb_rx_crc16_checker #(.MAX_PAYLOAD_BYTES(64)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pkt_start    (pkt_start),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .eop          (eop),
        .abort        (abort),
        .busy         (busy),
        .result_valid (result_valid),
        .crc_ok       (crc_ok),
        .len_err      (len_err),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       ok;
        bit       lerr;
        int       bc;
        int       at_cyc;
    } exp_t;

    typedef struct {
        string    name;
        int       n_bytes;     // payload bytes (CRC field appended)
        int       raw_bits;    // >=0: packet is this many zero bits, no CRC field
        bit       bad_crc;     // flip LSB of second CRC byte
        bit       coincident;  // eop in the same cycle as the last bit
        int       gap_pct;     // chance of an idle cycle before each bit
        bit       exp_ok;
        bit       exp_lerr;
        int       exp_bc;
    } vec_t;

    exp_t sb_q[$];
    bit   pkt_bits[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC register step from the polynomial taps.
    function automatic logic [15:0] model_step(input logic [15:0] c, input bit b);
        logic [15:0] n;
        n       = {c[14:0], 1'b0};
        n[0]    = c[15] ^ b;
        n[2]    = c[15] ^ c[1];
        n[15]   = c[15] ^ c[14];
        return n;
    endfunction

    // Builds payload bits LSB-first, then finds the 16-bit field that lands on 16'h800D.
    task automatic build_packet(input int n_bytes, input int raw_bits, input bit bad_crc);
        logic [15:0] s, t, good;
        logic [7:0]  d;
        logic [31:0] cv;
        bit          found;
        pkt_bits.delete();
        if (raw_bits >= 0) begin
            for (int i = 0; i < raw_bits; i++) pkt_bits.push_back(1'b0);
        end else begin
            s = 16'hFFFF;
            for (int b = 0; b < n_bytes; b++) begin
                d = 8'($urandom);
                for (int k = 0; k < 8; k++) begin
                    pkt_bits.push_back(d[k]);
                    s = model_step(s, d[k]);
                end
            end
            found = 1'b0;
            good  = 16'h0;
            for (int c = 0; c < 65536 && !found; c++) begin
                cv = 32'(c);
                t  = s;
                for (int k = 0; k < 16; k++) t = model_step(t, cv[k]);
                if (t == 16'h800D) begin
                    good  = cv[15:0];
                    found = 1'b1;
                end
            end
            check("crc_field_search", 32'(found), 32'd1);
            if (bad_crc) good[8] = ~good[8];
            for (int k = 0; k < 16; k++) pkt_bits.push_back(good[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit ok, input bit lerr, input int bc);
        exp_t e;
        e.ok     = ok;
        e.lerr   = lerr;
        e.bc     = bc;
        e.at_cyc = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic send_packet(input bit coincident, input int gap_pct,
                               input bit ok, input bit lerr, input int bc);
        int n;
        n = pkt_bits.size();
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) step();
            bit_valid = 1'b1;
            bit_in    = pkt_bits[i];
            if (coincident && i == n - 1) begin
                eop = 1'b1;
                push_exp(ok, lerr, bc);
            end
            step();
            bit_valid = 1'b0;
            bit_in    = 1'b0;
            eop       = 1'b0;
        end
        if (!coincident) begin
            eop = 1'b1;
            push_exp(ok, lerr, bc);
            step();
            eop = 1'b0;
        end
    endtask

    // Scoreboard: every result_valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_cycle", 32'(cyc), 32'(e.at_cyc));
                check("crc_ok", 32'(crc_ok), 32'(e.ok));
                check("len_err", 32'(len_err), 32'(e.lerr));
                check("byte_count", 32'(byte_count), 32'(e.bc));
            end
        end
    end

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"zero_len_good",  0, -1, 1'b0, 1'b0,  0, 1'b1, 1'b0,  0};
        vecs[1]  = '{"zero_len_bad",   0, -1, 1'b1, 1'b0,  0, 1'b0, 1'b0,  0};
        vecs[2]  = '{"bits_12",        0, 12, 1'b0, 1'b0,  0, 1'b0, 1'b1,  0};
        vecs[3]  = '{"bits_17",        0, 17, 1'b0, 1'b1,  0, 1'b0, 1'b1,  0};
        vecs[4]  = '{"bytes_67",      65, -1, 1'b0, 1'b0,  0, 1'b0, 1'b1,  0};
        vecs[5]  = '{"coincident",     0, -1, 1'b0, 1'b1,  0, 1'b1, 1'b0,  0};
        vecs[6]  = '{"gaps",           0, -1, 1'b0, 1'b0, 40, 1'b1, 1'b0,  0};
        vecs[7]  = '{"one_byte_good",  1, -1, 1'b0, 1'b0, 10, 1'b1, 1'b0,  1};
        vecs[8]  = '{"one_byte_bad",   1, -1, 1'b1, 1'b1,  0, 1'b0, 1'b0,  1};
        vecs[9]  = '{"max_payload",   64, -1, 1'b0, 1'b1, 20, 1'b1, 1'b0, 64};
        vecs[10] = '{"saturate_1040",128, -1, 1'b0, 1'b0,  0, 1'b0, 1'b1,  0};
        vecs[11] = '{"two_byte_bad",   2, -1, 1'b1, 1'b0, 30, 1'b0, 1'b0,  2};

        // Reset state.
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_crc_ok", 32'(crc_ok), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_engine_crc", 32'(dut.u_engine.crc), 32'hFFFF);
        n_rst = 1'b1;
        step();

        // Odd-indexed vectors return to IDLE and see stray eop/bit_valid there;
        // the rest start the next packet in the REPORT cycle.
        for (int v = 0; v < 12; v++) begin
            build_packet(vecs[v].n_bytes, vecs[v].raw_bits, vecs[v].bad_crc);
            send_packet(vecs[v].coincident, vecs[v].gap_pct,
                        vecs[v].exp_ok, vecs[v].exp_lerr, vecs[v].exp_bc);
            if (v % 2 == 1) begin
                step();
                eop       = 1'b1;
                bit_valid = 1'b1;
                step();
                eop       = 1'b0;
                bit_valid = 1'b0;
                step();
                check({vecs[v].name, "_held_crc_ok"}, 32'(crc_ok), 32'(vecs[v].exp_ok));
                check({vecs[v].name, "_held_len_err"}, 32'(len_err), 32'(vecs[v].exp_lerr));
                check({vecs[v].name, "_held_byte_count"}, 32'(byte_count), 32'(vecs[v].exp_bc));
            end
        end

        // Good packet, then an aborted one: no report, previous results untouched.
        build_packet(0, -1, 1'b0);
        send_packet(1'b0, 0, 1'b1, 1'b0, 0);
        step();
        step();
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bit_valid = 1'b1;
            bit_in    = pkt_bits[i];
            step();
        end
        bit_valid = 1'b0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        eop = 1'b1;
        step();
        eop = 1'b0;
        step();
        check("abort_busy_after_eop", 32'(busy), 32'd0);
        send_packet(1'b0, 0, 1'b1, 1'b0, 0);
        step();

        // Reset asserted while results are held, then mid-packet.
        build_packet(3, -1, 1'b0);
        send_packet(1'b0, 0, 1'b1, 1'b0, 3);
        step();
        #3;
        n_rst = 1'b0;
        #1;
        check("rst_idle_byte_count", 32'(byte_count), 32'd0);
        check("rst_idle_crc_ok", 32'(crc_ok), 32'd0);
        step();
        n_rst = 1'b1;
        step();
        build_packet(0, -1, 1'b0);
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1;
            bit_in    = ~pkt_bits[i];
            step();
        end
        bit_valid = 1'b0;
        #3;
        n_rst = 1'b0;
        #1;
        check("rst_accum_busy", 32'(busy), 32'd0);
        check("rst_accum_result_valid", 32'(result_valid), 32'd0);
        check("rst_accum_len_err", 32'(len_err), 32'd0);
        check("rst_accum_engine_crc", 32'(dut.u_engine.crc), 32'hFFFF);
        step();
        n_rst = 1'b1;
        step();
        send_packet(1'b1, 0, 1'b1, 1'b0, 0);

        for (int i = 0; i < 4; i++) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
